// File: rtl/fsu_stream_counter_if.sv
// Stream counter handshake bundle: start/stall/bit in, busy/valid/result out.
interface fsu_stream_counter_if #(
  parameter int CWID = 8
);
  logic            iStart;
  logic            iHold;
  logic            iBit;
  logic            oBusy;
  logic            oValid;
  logic [CWID+1:0] oData;

  // Controller / upstream side.
  modport master (
    output iStart,
    output iHold,
    output iBit,
    input  oBusy,
    input  oValid,
    input  oData
  );

  // Counter side.
  modport slave (
    input  iStart,
    input  iHold,
    input  iBit,
    output oBusy,
    output oValid,
    output oData
  );
endinterface

// File: rtl/fsu_stream_counter.sv
// Unary-to-binary stage: counts ones in a 2^CWID-sample window of the adder
// bitstream and reports the count (unipolar) or 2*count-N (bipolar) with a
// one-cycle valid pulse. iHold stalls sampling while a window is running.
module fsu_stream_counter #(
  parameter int CWID = 8,
  parameter bit BIPO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fsu_stream_counter_if.slave  bus
);

  localparam int unsigned NWIN = 32'd1 << CWID;
  localparam logic [CWID:0]   LAST_S = (CWID+1)'(NWIN - 1);
  localparam logic [CWID+1:0] NWIN_W = (CWID+2)'(NWIN);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [CWID:0]   scnt_q, scnt_d;
  logic [CWID:0]   ocnt_q, ocnt_d;
  logic [CWID+1:0] data_q, data_d;
  logic            valid_q, valid_d;

  // Final count including the bit sampled on the closing edge, and its
  // encodings. The doubled value needs CWID+2 bits; the subtraction wraps
  // into two's complement for counts below N/2.
  logic [CWID:0]   fcnt;
  logic [CWID+1:0] fcnt_w;
  logic [CWID+1:0] fres;

  // Final-count arithmetic and result encoding.
  always_comb begin
    fcnt   = ocnt_q + {{CWID{1'b0}}, bus.iBit};
    fcnt_w = {1'b0, fcnt};
    if (BIPO) begin
      fres = (fcnt_w << 1) - NWIN_W;
    end else begin
      fres = fcnt_w;
    end
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    ocnt_d  = ocnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          state_d = S_RUN;
          scnt_d  = '0;
          ocnt_d  = '0;
        end
      end
      S_RUN: begin
        if (!bus.iHold) begin
          if (scnt_q == LAST_S) begin
            data_d  = fres;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            scnt_d = scnt_q + 1'b1;
            ocnt_d = fcnt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset also aborts a window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      ocnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      ocnt_q  <= ocnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.oBusy  = (state_q == S_RUN);
  assign bus.oValid = valid_q;
  assign bus.oData  = data_q;

endmodule
